multicycle_controller: RTL

Control unit for the multicycle RV32I datapath. It is the successor to the single-cycle combinational decoder and covers lw, sw, R-type, I-type ALU, beq and jal. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback steps. A combinational ALU decoder and an immediate-source decoder sit alongside the FSM, and a parametrised retired-instruction counter is included.

---
 rtl/multicycle_controller_if.sv | 38 +++
 rtl/multicycle_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle RV32I datapath and its controller.
// The controller takes the slave view; the datapath (or a bench) takes the master view.
interface multicycle_controller_if #(
    parameter int unsigned ALUCTRL_W = 3,
    parameter int unsigned INSTRET_W = 32
);
    logic [6:0]           i_op;
    logic [2:0]           i_funct3;
    logic                 i_funct7b5;
    logic                 i_zero;

    logic                 o_pcWrite;
    logic                 o_adrSrc;
    logic                 o_memWrite;
    logic                 o_irWrite;
    logic [1:0]           o_resultSrc;
    logic [1:0]           o_aluSrcA;
    logic [1:0]           o_aluSrcB;
    logic [ALUCTRL_W-1:0] o_aluControl;
    logic [1:0]           o_immSrc;
    logic                 o_regWrite;
    logic                 o_illegal;
    logic [INSTRET_W-1:0] o_instret;

    modport slave (
        input  i_op, i_funct3, i_funct7b5, i_zero,
        output o_pcWrite, o_adrSrc, o_memWrite, o_irWrite, o_resultSrc,
               o_aluSrcA, o_aluSrcB, o_aluControl, o_immSrc, o_regWrite,
               o_illegal, o_instret
    );

    modport master (
        output i_op, i_funct3, i_funct7b5, i_zero,
        input  o_pcWrite, o_adrSrc, o_memWrite, o_irWrite, o_resultSrc,
               o_aluSrcA, o_aluSrcB, o_aluControl, o_immSrc, o_regWrite,
               o_illegal, o_instret
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore-FSM control unit for the multicycle RV32I datapath (lw, sw, R, I-ALU, beq, jal).
// Optional: define MULTICYCLE_CTRL_BNE_EN to let funct3=001 in the branch state act as bne.
module multicycle_controller #(
    parameter int unsigned ALUCTRL_W = 3,
    parameter int unsigned INSTRET_W = 32
) (
    input  logic                    i_clk,
    input  logic                    i_arst,
    multicycle_controller_if.slave  ctrl
);

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        JAL,
        BEQ
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd5
    } alu_fn_t;

    state_t state;
    state_t state_nxt;

    logic       pc_update;
    logic       branch;
    logic       branch_taken;
    logic [1:0] alu_op;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       illegal;

    alu_fn_t              alu_fn;
    logic [ALUCTRL_W-1:0] alu_control;
    logic [1:0]           imm_src;
    logic [INSTRET_W-1:0] instret;
    logic                 retire;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = FETCH;
        pc_update  = 1'b0;
        branch     = 1'b0;
        alu_op     = 2'b00;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        reg_write  = 1'b0;
        illegal    = 1'b0;

        case (state)
            FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
                state_nxt  = DECODE;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (ctrl.i_op)
                    OP_LW, OP_SW: state_nxt = MEMADR;
                    OP_RTYPE:     state_nxt = EXECUTER;
                    OP_ITYPE:     state_nxt = EXECUTEI;
                    OP_BEQ:       state_nxt = BEQ;
                    OP_JAL:       state_nxt = JAL;
                    default: begin
                        state_nxt = FETCH;
                        illegal   = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_nxt = (ctrl.i_op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src   = 1'b1;
                state_nxt = MEMWB;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_nxt  = FETCH;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                state_nxt = FETCH;
            end
            EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_nxt = ALUWB;
            end
            EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_nxt = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                state_nxt = FETCH;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_nxt = ALUWB;
            end
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
                state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

`ifdef MULTICYCLE_CTRL_BNE_EN
    assign branch_taken = ctrl.i_zero ^ (ctrl.i_funct3 == 3'b001);
`else
    assign branch_taken = ctrl.i_zero;
`endif

    // aluOp 11 never occurs; it falls into the funct3 decode like 10.
    always_comb begin
        alu_fn = ALU_ADD;
        case (alu_op)
            2'b00: alu_fn = ALU_ADD;
            2'b01: alu_fn = ALU_SUB;
            default: begin
                case (ctrl.i_funct3)
                    3'b000:  alu_fn = (ctrl.i_op[5] & ctrl.i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_fn = ALU_SLT;
                    3'b110:  alu_fn = ALU_OR;
                    3'b111:  alu_fn = ALU_AND;
                    default: alu_fn = ALU_ADD;
                endcase
            end
        endcase
    end

    always_comb begin
        alu_control      = '0;
        alu_control[2:0] = alu_fn;
    end

    always_comb begin
        case (ctrl.i_op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    // Every retiring state returns to FETCH unconditionally, so the state alone marks retirement.
    assign retire = (state == MEMWB) || (state == MEMWRITE) ||
                    (state == ALUWB) || (state == BEQ);

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + INSTRET_W'(1);
        end
    end

    assign ctrl.o_pcWrite    = pc_update | (branch & branch_taken);
    assign ctrl.o_adrSrc     = adr_src;
    assign ctrl.o_memWrite   = mem_write;
    assign ctrl.o_irWrite    = ir_write;
    assign ctrl.o_resultSrc  = result_src;
    assign ctrl.o_aluSrcA    = alu_src_a;
    assign ctrl.o_aluSrcB    = alu_src_b;
    assign ctrl.o_aluControl = alu_control;
    assign ctrl.o_immSrc     = imm_src;
    assign ctrl.o_regWrite   = reg_write;
    assign ctrl.o_illegal    = illegal;
    assign ctrl.o_instret    = instret;

endmodule
